// File: rtl/eig_pkg.sv
// Shared definitions for the multi-channel eigen core: regime codes, FSM
// states, sub-unit modes and the signed saturation constant.
package eig_pkg;

  localparam logic [2:0] REG_NONE  = 3'b000;
  localparam logic [2:0] REG_UNDER = 3'b001;
  localparam logic [2:0] REG_CRIT  = 3'b010;
  localparam logic [2:0] REG_OVER  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISC,
    ST_SQRT,
    ST_RECIP,
    ST_OUT
  } state_t;

  typedef enum logic {
    MODE_SQRT = 1'b0,
    MODE_DIV  = 1'b1
  } mode_t;

  // Largest positive value of a w-bit two's-complement word.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/serial_sqrt_div.sv
// Bit-serial restoring unit shared between integer square root and division.
// start loads the operands, then W iterations follow; done is high on the last one.
module serial_sqrt_div
  import eig_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           start,
  input  mode_t          mode,
  input  logic [2*W-1:0] opa,
  input  logic [W-1:0]   opd,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   result
);

  localparam int SW = W + 3;
  localparam int CW = $clog2(W + 1);

  logic [SW-1:0]  rem_reg, rem_next, rem_sh, trial;
  logic [SW:0]    diff;
  logic           ge;
  logic [2*W-1:0] sh_reg, sh_next;
  logic [W-1:0]   acc_reg, d_reg;
  logic [CW-1:0]  cnt_reg;
  logic           busy_reg;
  mode_t          mode_reg;

  // Sqrt consumes two radicand bits per step against 4*root+1; division one bit against d.
  always_comb begin
    rem_sh  = '0;
    trial   = '0;
    sh_next = sh_reg;
    if (mode_reg == MODE_SQRT) begin
      rem_sh  = {rem_reg[SW-3:0], sh_reg[2*W-1 -: 2]};
      trial   = {1'b0, acc_reg, 2'b01};
      sh_next = {sh_reg[2*W-3:0], 2'b00};
    end else begin
      rem_sh  = {rem_reg[SW-2:0], sh_reg[2*W-1]};
      trial   = {3'b000, d_reg};
      sh_next = {sh_reg[2*W-2:0], 1'b0};
    end
    diff     = {1'b0, rem_sh} - {1'b0, trial};
    ge       = ~diff[SW];
    rem_next = ge ? diff[SW-1:0] : rem_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg  <= '0;
      sh_reg   <= '0;
      acc_reg  <= '0;
      d_reg    <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      mode_reg <= MODE_SQRT;
    end else if (ena) begin
      if (start) begin
        mode_reg <= mode;
        d_reg    <= opd;
        acc_reg  <= '0;
        cnt_reg  <= '0;
        busy_reg <= 1'b1;
        if (mode == MODE_SQRT) begin
          rem_reg <= '0;
          sh_reg  <= opa;
        end else begin
          // The dividend's bit W seeds the remainder; bits W-1..0 are shifted in.
          rem_reg <= {{(SW-1){1'b0}}, opa[W]};
          sh_reg  <= {opa[W-1:0], {W{1'b0}}};
        end
      end else if (busy_reg) begin
        rem_reg <= rem_next;
        sh_reg  <= sh_next;
        acc_reg <= {acc_reg[W-2:0], ge};
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == CW'(W - 1)) busy_reg <= 1'b0;
      end
    end
  end

  assign busy   = busy_reg;
  assign done   = busy_reg & (cnt_reg == CW'(W - 1));
  assign result = acc_reg;

endmodule

// File: rtl/eig_core_mc.sv
// Multi-channel second-order eigen core: discriminant, regime, kappa, 1/kappa,
// sigma and per-channel regime-change flag, one job in flight at a time.
module eig_core_mc
  import eig_pkg::*;
#(
  parameter int  W      = 32,
  parameter int  F      = 16,
  parameter int  NUM_CH = 4,
  localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_alpha,
  input  logic [W-1:0]   in_beta,
  input  logic [CHW-1:0] in_ch,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [2:0]     regime,
  output logic [W-1:0]   kappa,
  output logic [W-1:0]   inv_kappa,
  output logic [W-1:0]   sigma,
  output logic           div0,
  output logic           inv_sat,
  output logic           regime_chg
);

  localparam logic [W-1:0] SAT = W'(sat_max(W));
  // 2^(2F) as the division dividend; bit W is the only bit above the shifted field (2F <= W).
  localparam logic [2*W-1:0] DIVIDEND = (2*W)'(1) << (2 * F);

  state_t state_reg, state_next;
  logic [W-1:0]   alpha_reg, beta_reg, kappa_reg;
  logic [CHW-1:0] ch_reg, tbl_idx;
  logic [2:0]     regime_reg;

  logic           out_valid_reg, div0_reg, inv_sat_reg, chg_reg;
  logic [CHW-1:0] out_ch_reg;
  logic [2:0]     regime_out_reg;
  logic [W-1:0]   kappa_out_reg, inv_reg, sigma_reg;

  logic accept, handshake, load_out;

  logic signed [2*W+1:0] b_ext, a_ext, disc;
  logic                  disc_neg;
  logic [2*W-1:0]        disc_abs;
  logic [2:0]            disc_regime;
  logic signed [W:0]     nb_pos, nb;
  logic [W-1:0]          sigma_calc;

  logic           sub_start, sub_busy, sub_done;
  mode_t          sub_mode;
  logic [2*W-1:0] sub_opa;
  logic [W-1:0]   sub_result;

  logic [2:0] last_regime [NUM_CH];
  logic [2:0] last_rd;

  assign in_ready  = ena & (state_reg == ST_IDLE);
  assign accept    = in_valid & in_ready;
  assign handshake = ena & (state_reg == ST_OUT) & out_valid_reg & out_ready;
  assign load_out  = ena & (state_reg == ST_OUT) & ~out_valid_reg;
  assign tbl_idx   = CHW'(32'(ch_reg) % NUM_CH);
  assign last_rd   = last_regime[tbl_idx];

  // Discriminant in 2W+2 bits with 2F fraction: beta^2 - alpha * 2^(F+2).
  always_comb begin
    b_ext       = {{(W+2){beta_reg[W-1]}}, beta_reg};
    a_ext       = {{(W+2){alpha_reg[W-1]}}, alpha_reg};
    disc        = (b_ext * b_ext) - (a_ext <<< (F + 2));
    disc_neg    = disc[2*W+1];
    disc_abs    = disc_neg ? (2*W)'(-disc) : disc[2*W-1:0];
    disc_regime = disc_neg ? REG_UNDER : ((disc == '0) ? REG_CRIT : REG_OVER);
    nb_pos      = {beta_reg[W-1], beta_reg};
    nb          = -nb_pos;
    sigma_calc  = W'(nb >>> 1);
  end

  assign sub_start = ena & ((state_reg == ST_DISC) | ((state_reg == ST_RECIP) & ~sub_busy));
  assign sub_mode  = (state_reg == ST_DISC) ? MODE_SQRT : MODE_DIV;
  assign sub_opa   = (state_reg == ST_DISC) ? disc_abs : DIVIDEND;

  serial_sqrt_div #(.W(W)) u_unit (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .start  (sub_start),
    .mode   (sub_mode),
    .opa    (sub_opa),
    .opd    (sub_result >> 1),
    .busy   (sub_busy),
    .done   (sub_done),
    .result (sub_result)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_DISC;
      ST_DISC:  if (ena) state_next = ST_SQRT;
      ST_SQRT:  if (ena && sub_done) state_next = ST_RECIP;
      ST_RECIP: if (ena && sub_done) state_next = ST_OUT;
      ST_OUT:   if (handshake) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alpha_reg      <= '0;
      beta_reg       <= '0;
      ch_reg         <= '0;
      regime_reg     <= REG_NONE;
      kappa_reg      <= '0;
      out_valid_reg  <= 1'b0;
      out_ch_reg     <= '0;
      regime_out_reg <= REG_NONE;
      kappa_out_reg  <= '0;
      inv_reg        <= '0;
      sigma_reg      <= '0;
      div0_reg       <= 1'b0;
      inv_sat_reg    <= 1'b0;
      chg_reg        <= 1'b0;
    end else begin
      if (accept) begin
        alpha_reg <= in_alpha;
        beta_reg  <= in_beta;
        ch_reg    <= in_ch;
      end
      if (ena && state_reg == ST_DISC) regime_reg <= disc_regime;
      if (ena && state_reg == ST_RECIP && !sub_busy) kappa_reg <= sub_result >> 1;
      if (load_out) begin
        out_valid_reg  <= 1'b1;
        out_ch_reg     <= ch_reg;
        regime_out_reg <= regime_reg;
        kappa_out_reg  <= kappa_reg;
        sigma_reg      <= sigma_calc;
        chg_reg        <= (regime_reg != last_rd);
        if (kappa_reg == '0) begin
          inv_reg     <= SAT;
          div0_reg    <= 1'b1;
          inv_sat_reg <= 1'b0;
        end else if (sub_result[W-1]) begin
          inv_reg     <= SAT;
          div0_reg    <= 1'b0;
          inv_sat_reg <= 1'b1;
        end else begin
          inv_reg     <= sub_result;
          div0_reg    <= 1'b0;
          inv_sat_reg <= 1'b0;
        end
      end
      if (handshake) out_valid_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_tbl
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_regime[gi] <= REG_NONE;
      else if (handshake && tbl_idx == CHW'(gi)) last_regime[gi] <= regime_out_reg;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_ch     = out_ch_reg;
  assign regime     = regime_out_reg;
  assign kappa      = kappa_out_reg;
  assign inv_kappa  = inv_reg;
  assign sigma      = sigma_reg;
  assign div0       = div0_reg;
  assign inv_sat    = inv_sat_reg;
  assign regime_chg = chg_reg;

endmodule

// File: tb/tb_eig_core_mc.sv
// Directed bench for eig_core_mc with hand-computed results (W=32, F=16).
module tb_eig_core_mc;

  localparam int W      = 32;
  localparam int F      = 16;
  localparam int NUM_CH = 4;
  localparam int CHW    = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ena = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   in_alpha = '0;
  logic [W-1:0]   in_beta = '0;
  logic [CHW-1:0] in_ch = '0;
  logic           in_ready, out_valid, div0, inv_sat, regime_chg;
  logic [CHW-1:0] out_ch;
  logic [2:0]     regime;
  logic [W-1:0]   kappa, inv_kappa, sigma;

  int n_chk = 0;
  int n_err = 0;
  int lat;

  eig_core_mc #(.W(W), .F(F), .NUM_CH(NUM_CH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_alpha   (in_alpha),
    .in_beta    (in_beta),
    .in_ch      (in_ch),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .regime     (regime),
    .kappa      (kappa),
    .inv_kappa  (inv_kappa),
    .sigma      (sigma),
    .div0       (div0),
    .inv_sat    (inv_sat),
    .regime_chg (regime_chg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [CHW-1:0] c);
    @(negedge clk);
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    in_alpha = a;
    in_beta  = b;
    in_ch    = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid; optionally drops ena for 5 edges.
  task automatic wait_valid(input int drop_at, output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (drop_at > 0 && n == drop_at) ena = 1'b0;
      if (drop_at > 0 && n == drop_at + 5) ena = 1'b1;
      if (out_valid) break;
    end
    chk("out_valid_seen", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic check_res(input string nm, input logic [2:0] reg_e, input logic [W-1:0] k_e,
                           input logic [W-1:0] inv_e, input logic [W-1:0] sig_e,
                           input logic div0_e, input logic sat_e, input logic chg_e,
                           input logic [CHW-1:0] ch_e, input int n, input int lat_e);
    $display("job %s: ch=%0d regime=%b kappa=%h inv=%h sigma=%h div0=%b sat=%b chg=%b lat=%0d",
             nm, out_ch, regime, kappa, inv_kappa, sigma, div0, inv_sat, regime_chg, n);
    chk({nm, "_latency"}, 64'(n), 64'(lat_e));
    chk({nm, "_regime"}, 64'(regime), 64'(reg_e));
    chk({nm, "_kappa"}, 64'(kappa), 64'(k_e));
    chk({nm, "_inv"}, 64'(inv_kappa), 64'(inv_e));
    chk({nm, "_sigma"}, 64'(sigma), 64'(sig_e));
    chk({nm, "_div0"}, {63'd0, div0}, {63'd0, div0_e});
    chk({nm, "_sat"}, {63'd0, inv_sat}, {63'd0, sat_e});
    chk({nm, "_chg"}, {63'd0, regime_chg}, {63'd0, chg_e});
    chk({nm, "_ch"}, 64'(out_ch), 64'(ch_e));
    chk({nm, "_in_ready_busy"}, {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({nm, "_valid_clr"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_kappa", 64'(kappa), 64'd0);
    chk("rst_regime", 64'(regime), 64'd0);
    chk("rst_inv", 64'(inv_kappa), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;

    send(32'h0001_0000, 32'h0002_0000, 2'd1);
    wait_valid(0, lat);
    check_res("crit", 3'b010, 32'h0, 32'h7FFF_FFFF, 32'hFFFF_0000, 1'b1, 1'b0, 1'b1, 2'd1, lat, 67);

    send(32'h0001_0000, 32'h0, 2'd2);
    wait_valid(0, lat);
    check_res("under", 3'b001, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 1'b1, 2'd2, lat, 67);

    send(32'h0001_0000, 32'h0, 2'd2);
    wait_valid(0, lat);
    check_res("under_rpt", 3'b001, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 1'b0, 2'd2, lat, 67);

    send(32'h0, 32'h0006_0000, 2'd0);
    wait_valid(0, lat);
    check_res("over", 3'b100, 32'h0003_0000, 32'h0000_5555, 32'hFFFD_0000, 1'b0, 1'b0, 1'b1, 2'd0, lat, 67);

    send(32'h0, 32'h0000_0002, 2'd3);
    wait_valid(0, lat);
    check_res("sat", 3'b100, 32'h1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 2'd3, lat, 67);

    // Backpressure: result must hold while out_ready stays low.
    send(32'h0, 32'h0006_0000, 2'd0);
    wait_valid(0, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_kappa", 64'(kappa), 64'h0003_0000);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    check_res("bp", 3'b100, 32'h0003_0000, 32'h0000_5555, 32'hFFFD_0000, 1'b0, 1'b0, 1'b0, 2'd0, lat, 67);

    send(32'h0001_0000, 32'h0, 2'd2);
    wait_valid(10, lat);
    check_res("ena_gap", 3'b001, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 1'b0, 2'd2, lat, 72);

    // Asynchronous reset while the reciprocal is iterating.
    send(32'h0, 32'h0006_0000, 2'd0);
    repeat (50) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_kappa", 64'(kappa), 64'd0);
    chk("mid_rst_inv", 64'(inv_kappa), 64'd0);
    chk("mid_rst_regime", 64'(regime), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(32'h0001_0000, 32'h0, 2'd2);
    wait_valid(0, lat);
    check_res("post_rst", 3'b001, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 1'b1, 2'd2, lat, 67);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
